// File: rtl/sdram_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port SDRAM controller.
// Port 0 is load/store, port 1 is instruction fetch; a watchdog aborts stuck transactions.
module sdram_arbiter #(
  parameter int unsigned RR      = 1,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [22:0] p0_addr,
  input  logic        p0_odd,
  input  logic [1:0]  p0_width,
  input  logic [31:0] p0_wdata,
  output logic        p0_done,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [22:0] p1_addr,
  input  logic        p1_odd,
  input  logic [1:0]  p1_width,
  input  logic [31:0] p1_wdata,
  output logic        p1_done,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        err,
  output logic        sd_enable,
  output logic [22:0] sd_addr,
  output logic        sd_odd,
  output logic        sd_write,
  output logic [1:0]  sd_width,
  output logic [31:0] sd_wdata,
  input  logic        sd_ready,
  input  logic [31:0] sd_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, BUSY} state_e;

  localparam logic [5:0] TO = 6'(TIMEOUT);

  state_e      state_q, state_d;
  logic        enable_q, enable_d;
  logic [22:0] addr_q, addr_d;
  logic        odd_q, odd_d;
  logic        write_q, write_d;
  logic [1:0]  width_q, width_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        err_q, err_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        gnt_q, gnt_d;
  logic        win;

  // Winning port index; only meaningful when at least one req is high.
  always_comb begin
    if (p0_req && p1_req) win = (RR != 0) ? ~last_q : 1'b0;
    else                  win = ~p0_req;
  end

  always_comb begin
    state_d  = state_q;
    enable_d = enable_q;
    addr_d   = addr_q;
    odd_d    = odd_q;
    write_d  = write_q;
    width_d  = width_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    err_d    = err_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    case (state_q)
      IDLE: begin
        // The done check leaves a one-cycle bubble after every completion.
        if (sd_ready && (p0_req || p1_req) && !done0_q && !done1_q) begin
          addr_d   = win ? p1_addr  : p0_addr;
          odd_d    = win ? p1_odd   : p0_odd;
          write_d  = win ? p1_we    : p0_we;
          width_d  = win ? p1_width : p0_width;
          wdata_d  = win ? p1_wdata : p0_wdata;
          gnt_d    = win;
          last_d   = win;
          enable_d = 1'b1;
          cnt_d    = '0;
          state_d  = REQ;
        end
      end
      REQ, BUSY: begin
        cnt_d = cnt_q + 6'd1;
        if (state_q == BUSY && sd_ready) begin
          done0_d = ~gnt_q;
          done1_d = gnt_q;
          if (!write_q) rdata_d = sd_rdata;
          state_d = IDLE;
        end else if (cnt_d == TO) begin
          err_d    = 1'b1;
          enable_d = 1'b0;
          rdata_d  = '0;
          done0_d  = ~gnt_q;
          done1_d  = gnt_q;
          state_d  = IDLE;
        end else if (state_q == REQ && !sd_ready) begin
          enable_d = 1'b0;
          state_d  = BUSY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      enable_q <= 1'b0;
      addr_q   <= '0;
      odd_q    <= 1'b0;
      write_q  <= 1'b0;
      width_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      addr_q   <= addr_d;
      odd_q    <= odd_d;
      write_q  <= write_d;
      width_q  <= width_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
    end
  end

  assign p0_done   = done0_q;
  assign p1_done   = done1_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;
  assign sd_enable = enable_q;
  assign sd_addr   = addr_q;
  assign sd_odd    = odd_q;
  assign sd_write  = write_q;
  assign sd_width  = width_q;
  assign sd_wdata  = wdata_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: round-robin and fixed-priority instances
// share stimulus and a behavioural SDRAM controller.
`timescale 1ns/1ps
module tb_sdram_arbiter;

  localparam int TO = 63;

  typedef struct packed {
    logic        we;
    logic [22:0] addr;
    logic        odd;
    logic [1:0]  width;
    logic [31:0] wdata;
  } cmd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        p0_req, p0_we, p0_odd, p1_req, p1_we, p1_odd;
  logic [22:0] p0_addr, p1_addr;
  logic [1:0]  p0_width, p1_width;
  logic [31:0] p0_wdata, p1_wdata;
  logic        sd_ready;
  logic [31:0] sd_rdata;

  logic        p0_done, p1_done, busy, err, sd_enable, sd_odd, sd_write;
  logic [31:0] rdata, sd_wdata;
  logic [22:0] sd_addr;
  logic [1:0]  sd_width;

  logic        fp_p0_done, fp_p1_done, fp_busy, fp_err, fp_sd_enable, fp_sd_odd, fp_sd_write;
  logic [31:0] fp_rdata, fp_sd_wdata;
  logic [22:0] fp_sd_addr;
  logic [1:0]  fp_sd_width;

  sdram_arbiter #(.RR(1), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_odd(p0_odd),
    .p0_width(p0_width), .p0_wdata(p0_wdata), .p0_done(p0_done),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_odd(p1_odd),
    .p1_width(p1_width), .p1_wdata(p1_wdata), .p1_done(p1_done),
    .rdata(rdata), .busy(busy), .err(err),
    .sd_enable(sd_enable), .sd_addr(sd_addr), .sd_odd(sd_odd), .sd_write(sd_write),
    .sd_width(sd_width), .sd_wdata(sd_wdata), .sd_ready(sd_ready), .sd_rdata(sd_rdata)
  );

  sdram_arbiter #(.RR(0), .TIMEOUT(TO)) dut_fp (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_odd(p0_odd),
    .p0_width(p0_width), .p0_wdata(p0_wdata), .p0_done(fp_p0_done),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_odd(p1_odd),
    .p1_width(p1_width), .p1_wdata(p1_wdata), .p1_done(fp_p1_done),
    .rdata(fp_rdata), .busy(fp_busy), .err(fp_err),
    .sd_enable(fp_sd_enable), .sd_addr(fp_sd_addr), .sd_odd(fp_sd_odd), .sd_write(fp_sd_write),
    .sd_width(fp_sd_width), .sd_wdata(fp_sd_wdata), .sd_ready(sd_ready), .sd_rdata(sd_rdata)
  );

  int vectors = 0;
  int miscompares = 0;

  cmd_t q0[$];
  cmd_t q1[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Data the controller model returns for a read of address a.
  function automatic logic [31:0] rd_val(logic [22:0] a);
    if (a == 23'h012345) return 32'hDEADBEEF;
    if (a == 23'h000777) return 32'h11112222;
    return ({9'd0, a} * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic cmd_t mk(logic we, logic [22:0] a, logic odd, logic [1:0] w, logic [31:0] d);
    cmd_t c;
    c.we = we; c.addr = a; c.odd = odd; c.width = w; c.wdata = d;
    return c;
  endfunction

  function automatic cmd_t rnd_cmd();
    return mk(1'($urandom), 23'($urandom), 1'($urandom), 2'($urandom_range(0, 2)), $urandom);
  endfunction

  // ---------------- behavioural SDRAM controller ----------------
  bit ctl_on = 0;
  bit ctl_hang = 0;
  int ctl_refresh = -1;
  int c_ph = 0, c_left = 0, c_bleft = 0;
  logic c_rd;
  logic [22:0] c_addr;

  initial begin
    sd_ready = 1'b0;
    sd_rdata = '0;
    forever begin
      @(negedge clk);
      sd_rdata = $urandom;
      if (rst || !ctl_on) begin
        c_ph = 0;
        sd_ready = ctl_on;
      end else begin
        if (c_ph == 0) begin
          sd_ready = 1'b1;
          if (sd_enable) begin
            c_addr = sd_addr;
            c_rd   = !sd_write;
            c_left = (ctl_refresh >= 0) ? ctl_refresh : int'($urandom_range(0, 3));
            c_ph   = 1;
          end
        end
        if (c_ph == 1) begin
          if (!sd_enable) c_ph = 0;
          else if (ctl_hang) sd_ready = 1'b1;
          else if (c_left == 0) begin
            sd_ready = 1'b0;
            c_bleft  = int'($urandom_range(0, 3));
            c_ph     = 2;
          end else begin
            c_left--;
            sd_ready = 1'b1;
          end
        end else if (c_ph == 2) begin
          if (c_bleft == 0) begin
            sd_ready = 1'b1;
            if (c_rd) sd_rdata = rd_val(c_addr);
            c_ph = 0;
          end else c_bleft--;
        end
      end
    end
  end

  // ---------------- reference model + monitor ----------------
  bit   m_inflight = 0, m_busyph = 0, m_prev_done = 0, m_err = 0, m_last = 1;
  int   m_k = 0, m_gp = 0, m_fgp = 0, m_w = 0, m_ed = -1, m_qs = 0;
  cmd_t m_g = '0;
  logic [31:0] m_lrd = '0;
  logic m_r0, m_r1, m_rdy, m_en;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_r0 = p0_req; m_r1 = p1_req; m_rdy = sd_ready;
      m_ed = -1;
      if (rst) begin
        m_inflight = 0; m_busyph = 0; m_prev_done = 0; m_err = 0; m_last = 1;
        m_g = '0; m_lrd = '0;
      end else if (m_inflight) begin
        m_k++;
        if (m_busyph && m_rdy) begin
          m_ed = m_gp;
          if (!m_g.we) m_lrd = rd_val(m_g.addr);
          m_inflight = 0;
        end else if (m_k == TO) begin
          m_ed = m_gp; m_lrd = '0; m_err = 1; m_inflight = 0;
        end else if (!m_busyph && !m_rdy) m_busyph = 1;
      end else if (m_rdy && (m_r0 || m_r1) && !m_prev_done) begin
        if (m_r0 && m_r1) m_w = m_last ? 0 : 1;
        else              m_w = m_r0 ? 0 : 1;
        m_last = (m_w == 1); m_gp = m_w;
        m_inflight = 1; m_busyph = 0; m_k = 0;
        m_qs = (m_w == 0) ? q0.size() : q1.size();
        chk("grant_has_cmd", 32'(m_qs != 0), 32'd1);
        if (m_qs != 0) m_g = (m_w == 0) ? q0.pop_front() : q1.pop_front();
        m_fgp = m_r0 ? 0 : 1;
        chk("fp_sd_addr", 32'(fp_sd_addr), 32'(m_fgp == 1 ? p1_addr : p0_addr));
        chk("fp_sd_write", 32'(fp_sd_write), 32'(m_fgp == 1 ? p1_we : p0_we));
      end
      m_en = m_inflight && !m_busyph;
      chk("sd_enable", 32'(sd_enable), 32'(m_en));
      chk("busy", 32'(busy), 32'(m_inflight));
      chk("err", 32'(err), 32'(m_err));
      chk("p0_done", 32'(p0_done), 32'(m_ed == 0));
      chk("p1_done", 32'(p1_done), 32'(m_ed == 1));
      chk("rdata", rdata, m_lrd);
      chk("sd_addr", 32'(sd_addr), 32'(m_g.addr));
      chk("sd_write", 32'(sd_write), 32'(m_g.we));
      chk("sd_odd", 32'(sd_odd), 32'(m_g.odd));
      chk("sd_width", 32'(sd_width), 32'(m_g.width));
      chk("sd_wdata", sd_wdata, m_g.wdata);
      chk("fp_sd_enable", 32'(fp_sd_enable), 32'(m_en));
      chk("fp_busy", 32'(fp_busy), 32'(m_inflight));
      chk("fp_err", 32'(fp_err), 32'(m_err));
      chk("fp_p0_done", 32'(fp_p0_done), 32'(m_ed >= 0 && m_fgp == 0));
      chk("fp_p1_done", 32'(fp_p1_done), 32'(m_ed >= 0 && m_fgp == 1));
      m_prev_done = (m_ed >= 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(int p, cmd_t c);
    if (p == 0) begin
      p0_we = c.we; p0_addr = c.addr; p0_odd = c.odd; p0_width = c.width; p0_wdata = c.wdata;
      p0_req = 1'b1; q0.push_back(c);
    end else begin
      p1_we = c.we; p1_addr = c.addr; p1_odd = c.odd; p1_width = c.width; p1_wdata = c.wdata;
      p1_req = 1'b1; q1.push_back(c);
    end
  endtask

  task automatic wait_done(int p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(p == 0 ? p0_done : p1_done) && n < 300);
    chk(p == 0 ? "p0_done_within_bound" : "p1_done_within_bound", 32'(n < 300), 32'd1);
    if (p == 0) p0_req = 1'b0; else p1_req = 1'b0;
  endtask

  task automatic txn(int p, cmd_t c);
    drive(p, c);
    wait_done(p);
  endtask

  task automatic port_run(int p, int n, bit cont);
    for (int i = 0; i < n; i++) begin
      txn(p, rnd_cmd());
      if (!cont) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
  endtask

  initial begin
    #500000;
    miscompares++;
    $display("FAIL sim_time_limit: still running at %0t, required to finish earlier", $time);
    summary();
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_odd = 0; p0_width = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_odd = 0; p1_width = '0; p1_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Tie while the controller is still initialising: no grant until ready, then port 0.
    drive(0, mk(1'b0, 23'h012345, 1'b0, 2'b10, 32'h0));
    drive(1, mk(1'b0, 23'h000777, 1'b0, 2'b01, 32'h0));
    repeat (5) @(negedge clk);
    chk("no_enable_while_not_ready", 32'(sd_enable), 32'd0);
    ctl_on = 1;
    fork
      wait_done(0);
      wait_done(1);
    join

    @(negedge clk);
    txn(0, mk(1'b0, 23'h012345, 1'b0, 2'b10, 32'h0));
    chk("read_deadbeef", rdata, 32'hDEADBEEF);
    @(negedge clk);
    txn(1, mk(1'b0, 23'h000777, 1'b1, 2'b01, 32'h0));
    chk("read_11112222", rdata, 32'h11112222);
    @(negedge clk);
    txn(1, mk(1'b1, 23'h000888, 1'b1, 2'b10, 32'hCAFEF00D));
    chk("write_keeps_rdata", rdata, 32'h11112222);

    // Controller in refresh: ready held high for several cycles after enable.
    ctl_refresh = 5;
    @(negedge clk);
    txn(0, mk(1'b0, 23'h0000AA, 1'b0, 2'b00, 32'h0));
    @(negedge clk);
    txn(1, rnd_cmd());
    ctl_refresh = -1;

    // Random traffic: back-to-back on both ports, then with gaps.
    @(negedge clk);
    fork
      port_run(0, 40, 1'b1);
      port_run(1, 40, 1'b1);
    join
    fork
      port_run(0, 40, 1'b0);
      port_run(1, 40, 1'b0);
    join

    // Stuck controller: watchdog abort, then normal service with err sticky.
    ctl_hang = 1;
    @(negedge clk);
    txn(1, mk(1'b0, 23'h000123, 1'b0, 2'b10, 32'h0));
    chk("abort_rdata", rdata, 32'h0);
    chk("abort_err", 32'(err), 32'd1);
    ctl_hang = 0;
    @(negedge clk);
    txn(0, mk(1'b0, 23'h012345, 1'b0, 2'b10, 32'h0));
    chk("err_sticky", 32'(err), 32'd1);
    chk("read_after_abort", rdata, 32'hDEADBEEF);

    // Reset in the middle of a transaction: no done, err cleared.
    @(negedge clk);
    drive(0, mk(1'b0, 23'h000321, 1'b0, 2'b01, 32'h0));
    for (int i = 0; i < 20 && !sd_enable; i++) @(negedge clk);
    chk("enable_before_reset", 32'(sd_enable), 32'd1);
    rst = 1'b1;
    p0_req = 1'b0;
    q0.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("err_cleared_by_reset", 32'(err), 32'd0);

    // Fresh tie after reset goes to port 0 again.
    drive(1, mk(1'b0, 23'h000777, 1'b0, 2'b10, 32'h0));
    drive(0, mk(1'b1, 23'h000999, 1'b0, 2'b10, 32'h12345678));
    fork
      wait_done(0);
      wait_done(1);
    join
    repeat (3) @(negedge clk);

    summary();
    $finish;
  end

endmodule
